// File: rtl/click_to_sync_bridge_if.sv
// Bundle of the asynchronous request/ack pair and the synchronous
// valid/ready output port of click_to_sync_bridge.
interface click_to_sync_bridge_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  inR;
    logic [DATA_WIDTH-1:0] inData;
    logic                  outA;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Source/consumer side: drives request, bundled data and ready.
    modport master (
        output inR, inData, out_ready,
        input  outA, out_valid, out_data
    );

    // Bridge side.
    modport slave (
        input  inR, inData, out_ready,
        output outA, out_valid, out_data
    );
endinterface

// File: rtl/click_to_sync_bridge.sv
// Boundary between a click-controlled (2-phase) pipeline and clocked logic.
// The toggle request is synchronized into clk, the bundled data is captured
// into a 2-entry FIFO, a 2-phase ack is returned, and the FIFO head is
// offered on a valid/ready port. A transfer counter tracks completed pops.
module click_to_sync_bridge #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    click_to_sync_bridge_if.slave    bus,
    output logic [1:0]               occupancy,
    output logic [CNT_WIDTH-1:0]     xfer_cnt
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   req_pending;
    logic                   req_seen_q, req_seen_d;
    logic                   outA_q, outA_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    slot_e                  slot_q [2];
    slot_e                  slot_d [2];
    logic [DATA_WIDTH-1:0]  mem_q [2];
    logic [DATA_WIDTH-1:0]  mem_d [2];
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   push;
    logic                   pop;

    // Plain flop chain bringing inR into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.inR};
        end
    end

    // Occupancy and push/pop qualification, all from registered state.
    always_comb begin
        req_sync    = sync_q[SYNC_STAGES-1];
        req_pending = req_sync ^ req_seen_q;
        occupancy   = {1'b0, slot_q[0] == SLOT_FULL} + {1'b0, slot_q[1] == SLOT_FULL};
        // Full check uses registered occupancy only: a same-cycle pop never
        // frees room for a push, keeping ready-to-push free of comb paths.
        push        = req_pending && (occupancy != 2'd2);
        pop         = (occupancy != 2'd0) && bus.out_ready;
    end

    // Next-state for slot FSMs, pointers, ack phase and transfer counter.
    always_comb begin
        slot_d     = slot_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        req_seen_d = req_seen_q;
        outA_d     = outA_q;
        cnt_d      = cnt_q;
        if (pop) begin
            slot_d[rd_ptr_q] = SLOT_EMPTY;
            rd_ptr_d         = ~rd_ptr_q;
            cnt_d            = cnt_q + CNT_WIDTH'(1);
        end
        if (push) begin
            slot_d[wr_ptr_q] = SLOT_FULL;
            mem_d[wr_ptr_q]  = bus.inData;
            wr_ptr_d         = ~wr_ptr_q;
            req_seen_d       = req_sync;
            outA_d           = ~outA_q;
        end
    end

    // State registers; reset drops FIFO contents and any pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0]  <= SLOT_EMPTY;
            slot_q[1]  <= SLOT_EMPTY;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            req_seen_q <= 1'b0;
            outA_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            slot_q     <= slot_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            req_seen_q <= req_seen_d;
            outA_q     <= outA_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.outA      = outA_q;
    assign bus.out_valid = (occupancy != 2'd0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign xfer_cnt      = cnt_q;

endmodule
